hls_mem_server: RTL and testbench

Word-addressed memory server sitting directly downstream of the CPU-to-HLS bus bridge. It pops one command at a time from the seven command FIFOs the bridge fills, and applies byte-masked writes to an internal single-port RAM. Reads produce one word, or a cache-line burst, into the two response FIFOs that the bridge drains back onto the CPU data bus.

---
 rtl/hls_mem_server.sv | 161 ++++++++++++++++
 tb/tb_hls_mem_server.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_mem_server.sv
// Word-addressed memory server: pops lockstep command FIFOs, applies byte-masked RAM writes,
// and streams read beats into the response FIFOs. Cache-line bursts enabled by HLS_MEM_SERVER_BURST_EN.
module hls_mem_server #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2  = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_ADDR_WIDTH-1:0] io_bus_cmd_payload_address_V_dout,
  input  logic                       io_bus_cmd_payload_address_V_empty_n,
  output logic                       io_bus_cmd_payload_address_V_read,
  input  logic [DATA_WIDTH-1:0]      io_bus_cmd_payload_data_V_dout,
  input  logic                       io_bus_cmd_payload_data_V_empty_n,
  output logic                       io_bus_cmd_payload_data_V_read,
  input  logic [3:0]                 io_bus_cmd_payload_mask_V_dout,
  input  logic                       io_bus_cmd_payload_mask_V_empty_n,
  output logic                       io_bus_cmd_payload_mask_V_read,
  input  logic                       io_bus_cmd_payload_write_V_dout,
  input  logic                       io_bus_cmd_payload_write_V_empty_n,
  output logic                       io_bus_cmd_payload_write_V_read,
  input  logic                       io_bus_cmd_payload_uncached_V_dout,
  input  logic                       io_bus_cmd_payload_uncached_V_empty_n,
  output logic                       io_bus_cmd_payload_uncached_V_read,
  input  logic [2:0]                 io_bus_cmd_payload_size_V_dout,
  input  logic                       io_bus_cmd_payload_size_V_empty_n,
  output logic                       io_bus_cmd_payload_size_V_read,
  input  logic                       io_bus_cmd_payload_last_V_dout,
  input  logic                       io_bus_cmd_payload_last_V_empty_n,
  output logic                       io_bus_cmd_payload_last_V_read,
  output logic [DATA_WIDTH-1:0]      io_bus_rsp_payload_data_V_din,
  input  logic                       io_bus_rsp_payload_data_V_full_n,
  output logic                       io_bus_rsp_payload_data_V_write,
  output logic                       io_bus_rsp_payload_last_V_din,
  input  logic                       io_bus_rsp_payload_last_V_full_n,
  output logic                       io_bus_rsp_payload_last_V_write
);

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_e;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     mem_q [2**MEM_DEPTH_LOG2];
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [3:0]                mask_q;
  logic [MEM_DEPTH_LOG2-1:0] idx_q;
  logic [MEM_DEPTH_LOG2-1:0] rd_idx;
  logic                      cmd_avail, cmd_read, rsp_write, last_beat;

  assign cmd_avail = io_bus_cmd_payload_address_V_empty_n & io_bus_cmd_payload_data_V_empty_n &
                     io_bus_cmd_payload_mask_V_empty_n & io_bus_cmd_payload_write_V_empty_n &
                     io_bus_cmd_payload_uncached_V_empty_n & io_bus_cmd_payload_size_V_empty_n &
                     io_bus_cmd_payload_last_V_empty_n;
  // Gated by rst_n so no FIFO is popped while reset is held.
  assign cmd_read  = rst_n && (state_q == IDLE) && cmd_avail;
  assign rsp_write = (state_q == RSP) && io_bus_rsp_payload_data_V_full_n &&
                     io_bus_rsp_payload_last_V_full_n;

`ifdef HLS_MEM_SERVER_BURST_EN
  logic [4:0] beat_q, beat_d, beats_m1_q, beats_m1_d;

  function automatic logic [4:0] beats_m1_of(input logic [2:0] size);
    case (size)
      3'd3:    return 5'd1;
      3'd4:    return 5'd3;
      3'd5:    return 5'd7;
      3'd6:    return 5'd15;
      3'd7:    return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  assign last_beat = (beat_q == beats_m1_q);
  // Burst base is the line-aligned index; the beat offset wraps inside the RAM.
  assign rd_idx = (idx_q & ~MEM_DEPTH_LOG2'(beats_m1_q)) + MEM_DEPTH_LOG2'(beat_q);

  always_comb begin
    beat_d     = beat_q;
    beats_m1_d = beats_m1_q;
    if (cmd_read) begin
      beat_d     = '0;
      beats_m1_d = beats_m1_of(io_bus_cmd_payload_size_V_dout);
    end else if (rsp_write && !last_beat) begin
      beat_d = beat_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q     <= '0;
      beats_m1_q <= '0;
    end else begin
      beat_q     <= beat_d;
      beats_m1_q <= beats_m1_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{io_bus_cmd_payload_uncached_V_dout, io_bus_cmd_payload_last_V_dout,
                         io_bus_cmd_payload_address_V_dout[DATA_ADDR_WIDTH-1:MEM_DEPTH_LOG2]};
`else
  assign last_beat = 1'b1;
  assign rd_idx    = idx_q;

  logic unused_bits;
  assign unused_bits = ^{io_bus_cmd_payload_uncached_V_dout, io_bus_cmd_payload_last_V_dout,
                         io_bus_cmd_payload_size_V_dout,
                         io_bus_cmd_payload_address_V_dout[DATA_ADDR_WIDTH-1:MEM_DEPTH_LOG2]};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_read) state_d = io_bus_cmd_payload_write_V_dout ? WR : RD;
      WR:      state_d = IDLE;
      RD:      state_d = RSP;
      RSP:     if (rsp_write) state_d = last_beat ? IDLE : RD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (cmd_read) begin
      idx_q   <= io_bus_cmd_payload_address_V_dout[MEM_DEPTH_LOG2-1:0];
      wdata_q <= io_bus_cmd_payload_data_V_dout;
      mask_q  <= io_bus_cmd_payload_mask_V_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == WR) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // Output register only loads in RD, so din holds steady while RSP is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rdata_q <= '0;
    else if (state_q == RD)  rdata_q <= mem_q[rd_idx];
  end

  assign io_bus_cmd_payload_address_V_read  = cmd_read;
  assign io_bus_cmd_payload_data_V_read     = cmd_read;
  assign io_bus_cmd_payload_mask_V_read     = cmd_read;
  assign io_bus_cmd_payload_write_V_read    = cmd_read;
  assign io_bus_cmd_payload_uncached_V_read = cmd_read;
  assign io_bus_cmd_payload_size_V_read     = cmd_read;
  assign io_bus_cmd_payload_last_V_read     = cmd_read;
  assign io_bus_rsp_payload_data_V_din      = rdata_q;
  assign io_bus_rsp_payload_last_V_din      = last_beat;
  assign io_bus_rsp_payload_data_V_write    = rsp_write;
  assign io_bus_rsp_payload_last_V_write    = rsp_write;

endmodule

// File: tb/tb_hls_mem_server.sv
// Bench for hls_mem_server: queue-based command/response FIFOs and an array memory model.
module tb_hls_mem_server;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;
`ifdef HLS_MEM_SERVER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        wr;
    logic [2:0]  size;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_t cq[$];
  cmd_t head = '0;
  logic have = 1'b0;
  logic mask_block = 1'b0;
  logic data_full_n = 1'b1, last_full_n = 1'b1;
  logic rd_addr, rd_data, rd_mask, rd_write, rd_unc, rd_size, rd_last;
  logic [31:0] din_data;
  logic din_last, wr_data, wr_last;

  logic [31:0] mref [DEPTH];
  logic [32:0] rsp_q[$];
  int          rsp_cyc[$];
  logic [32:0] exp_q[$];
  int cyc = 0, pop_count = 0, last_pop_cyc = 0;
  int total = 0, bad = 0;
  logic pop_pend;

  hls_mem_server #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32), .MEM_DEPTH_LOG2(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_bus_cmd_payload_address_V_dout(head.addr), .io_bus_cmd_payload_address_V_empty_n(have),
    .io_bus_cmd_payload_address_V_read(rd_addr),
    .io_bus_cmd_payload_data_V_dout(head.data), .io_bus_cmd_payload_data_V_empty_n(have),
    .io_bus_cmd_payload_data_V_read(rd_data),
    .io_bus_cmd_payload_mask_V_dout(head.mask), .io_bus_cmd_payload_mask_V_empty_n(have && !mask_block),
    .io_bus_cmd_payload_mask_V_read(rd_mask),
    .io_bus_cmd_payload_write_V_dout(head.wr), .io_bus_cmd_payload_write_V_empty_n(have),
    .io_bus_cmd_payload_write_V_read(rd_write),
    .io_bus_cmd_payload_uncached_V_dout(head.addr[1]), .io_bus_cmd_payload_uncached_V_empty_n(have),
    .io_bus_cmd_payload_uncached_V_read(rd_unc),
    .io_bus_cmd_payload_size_V_dout(head.size), .io_bus_cmd_payload_size_V_empty_n(have),
    .io_bus_cmd_payload_size_V_read(rd_size),
    .io_bus_cmd_payload_last_V_dout(head.addr[2]), .io_bus_cmd_payload_last_V_empty_n(have),
    .io_bus_cmd_payload_last_V_read(rd_last),
    .io_bus_rsp_payload_data_V_din(din_data), .io_bus_rsp_payload_data_V_full_n(data_full_n),
    .io_bus_rsp_payload_data_V_write(wr_data),
    .io_bus_rsp_payload_last_V_din(din_last), .io_bus_rsp_payload_last_V_full_n(last_full_n),
    .io_bus_rsp_payload_last_V_write(wr_last)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: sample strobes mid-cycle, commit pops just after the edge.
  always begin
    @(negedge clk);
    pop_pend = rd_addr;
    if (rd_addr) last_pop_cyc = cyc;
    if (wr_data && data_full_n && last_full_n) begin
      rsp_q.push_back({din_last, din_data});
      rsp_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (pop_pend && rst_n && cq.size() > 0) begin
      void'(cq.pop_front());
      pop_count++;
    end
    have = (cq.size() > 0);
    if (have) head = cq[0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_beats(input logic [2:0] size);
    if (BURST && size > 3'd2) return 1 << (size - 3'd2);
    return 1;
  endfunction

  task automatic push_cmd(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                          input logic wr, input logic [2:0] size);
    logic [AW-1:0] i;
    cq.push_back('{addr: addr, data: data, mask: mask, wr: wr, size: size});
    if (wr) begin
      i = addr[AW-1:0];
      for (int l = 0; l < 4; l++) if (mask[l]) mref[i][8*l +: 8] = data[8*l +: 8];
    end
  endtask

  task automatic build_exp(input logic [31:0] addr, input logic [2:0] size);
    int nb;
    logic [AW-1:0] base, a;
    nb = exp_beats(size);
    base = addr[AW-1:0] & ~AW'(nb - 1);
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      a = base + AW'(b);
      exp_q.push_back({b == nb - 1, mref[a]});
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    int budget;
    push_cmd(addr, data, mask, 1'b1, 3'd2);
    budget = 50;
    while (cq.size() > 0 && budget > 0) begin step(); budget--; end
    step(); step();
  endtask

  task automatic wait_beats(input int n);
    int budget;
    budget = 40 * n + 40;
    while (rsp_q.size() < n && budget > 0) begin step(); budget--; end
    step(); step(); step();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] size);
    rsp_q.delete(); rsp_cyc.delete();
    build_exp(addr, size);
    push_cmd(addr, 32'h0, 4'h0, 1'b0, size);
    wait_beats(exp_q.size());
  endtask

  task automatic test_reset();
    push_cmd(32'd200, 32'hC0FFEE01, 4'hF, 1'b1, 3'd2);
    step(); step(); step();
    total++; if ({rd_addr, rd_data, rd_mask, rd_write, rd_unc, rd_size, rd_last} !== 7'b0) begin
      bad++; $display("FAIL reset_read got=%b exp=0000000", {rd_addr, rd_data, rd_mask, rd_write, rd_unc, rd_size, rd_last});
    end
    total++; if ({wr_data, wr_last} !== 2'b00) begin bad++; $display("FAIL reset_write got=%b exp=00", {wr_data, wr_last}); end
    total++; if (din_data !== 32'h0) begin bad++; $display("FAIL reset_din got=%h exp=0", din_data); end
    total++; if (din_last !== 1'b1) begin bad++; $display("FAIL reset_last got=%b exp=1", din_last); end
    total++; if (pop_count !== 0) begin bad++; $display("FAIL reset_pops got=%0d exp=0", pop_count); end
    rst_n = 1'b1;
    begin int budget = 50; while (cq.size() > 0 && budget > 0) begin step(); budget--; end end
    step(); step();
  endtask

  task automatic test_full_write_read();
    do_write(32'd5, 32'hDEADBEEF, 4'hF);
    do_read(32'd5, 3'd2);
    total++; if (rsp_q.size() !== 1) begin bad++; $display("FAIL fwr_count got=%0d exp=1", rsp_q.size()); end
    else begin
      total++; if (rsp_q[0] !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL fwr_beat got=%h exp=1deadbeef", rsp_q[0]); end
      total++; if (rsp_cyc[0] - last_pop_cyc !== 2) begin bad++; $display("FAIL fwr_latency got=%0d exp=2", rsp_cyc[0] - last_pop_cyc); end
    end
  endtask

  task automatic test_byte_mask();
    do_write(32'd7, 32'h11223344, 4'hF);
    do_write(32'd7, 32'hAABBCCDD, 4'h5);
    do_read(32'd7, 3'd0);
    total++; if (rsp_q.size() !== 1 || rsp_q[0] !== {1'b1, 32'h11BB33DD}) begin
      bad++; $display("FAIL mask_merge got=%h n=%0d exp=111bb33dd", (rsp_q.size() > 0) ? rsp_q[0] : 33'h0, rsp_q.size());
    end
  endtask

  task automatic test_burst();
    for (int w = 8; w < 16; w++) do_write(w, w, 4'hF);
    do_read(32'd10, 3'd5);
    total++; if (rsp_q.size() !== exp_q.size()) begin bad++; $display("FAIL burst_count got=%0d exp=%0d", rsp_q.size(), exp_q.size()); end
    else for (int b = 0; b < exp_q.size(); b++) begin
      total++; if (rsp_q[b] !== exp_q[b]) begin bad++; $display("FAIL burst_beat%0d got=%h exp=%h", b, rsp_q[b], exp_q[b]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 64; i++) do_write(i + (32'($urandom_range(0, 3)) << AW), $urandom, 4'hF);
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      a[AW-1:6] = '0;
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom));
      else begin
        do_read(a, 3'($urandom_range(0, 7)));
        total++; if (rsp_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, rsp_q.size(), exp_q.size()); end
        else for (int b = 0; b < exp_q.size(); b++) begin
          total++; if (rsp_q[b] !== exp_q[b]) begin bad++; $display("FAIL rand_beat n=%0d b=%0d got=%h exp=%h", n, b, rsp_q[b], exp_q[b]); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] snap;
    int budget;
    rsp_q.delete(); rsp_cyc.delete();
    build_exp(32'd32, 3'd4);
    push_cmd(32'd32, 32'h0, 4'h0, 1'b0, 3'd4);
    budget = 60;
    while (rsp_q.size() < 1 && budget > 0) begin step(); budget--; end
    data_full_n = 1'b0;
    step();
    total++; if ({wr_data, wr_last} !== 2'b00) begin bad++; $display("FAIL bp_strobe c=0 got=%b exp=00", {wr_data, wr_last}); end
    snap = din_data;
    for (int c = 1; c < 5; c++) begin
      step();
      total++; if ({wr_data, wr_last} !== 2'b00) begin bad++; $display("FAIL bp_strobe c=%0d got=%b exp=00", c, {wr_data, wr_last}); end
      total++; if (din_data !== snap) begin bad++; $display("FAIL bp_din c=%0d got=%h exp=%h", c, din_data, snap); end
    end
    data_full_n = 1'b1;
    wait_beats(exp_q.size());
    total++; if (rsp_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", rsp_q.size(), exp_q.size()); end
    else for (int b = 0; b < exp_q.size(); b++) begin
      total++; if (rsp_q[b] !== exp_q[b]) begin bad++; $display("FAIL bp_beat%0d got=%h exp=%h", b, rsp_q[b], exp_q[b]); end
    end
    // Only the last-beat FIFO full: strobes must still stay low.
    rsp_q.delete(); rsp_cyc.delete();
    build_exp(32'd40, 3'd0);
    last_full_n = 1'b0;
    push_cmd(32'd40, 32'h0, 4'h0, 1'b0, 3'd0);
    for (int c = 0; c < 6; c++) begin
      step();
      total++; if ({wr_data, wr_last} !== 2'b00) begin bad++; $display("FAIL bp_lastfull c=%0d got=%b exp=00", c, {wr_data, wr_last}); end
    end
    last_full_n = 1'b1;
    wait_beats(1);
    total++; if (rsp_q.size() !== 1 || rsp_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL bp_lastfull_beat n=%0d got=%h exp=%h", rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : 33'h0, exp_q[0]);
    end
  endtask

  task automatic test_lockstep_alias();
    int pops0, budget;
    logic [31:0] v;
    v = $urandom;
    pops0 = pop_count;
    mask_block = 1'b1;
    push_cmd(DEPTH + 3, v, 4'hF, 1'b1, 3'd2);
    repeat (6) step();
    total++; if (pop_count !== pops0 || rd_addr !== 1'b0) begin
      bad++; $display("FAIL lockstep_pop got=%0d strobe=%b exp=%0d strobe=0", pop_count - pops0, rd_addr, 0);
    end
    mask_block = 1'b0;
    budget = 50;
    while (cq.size() > 0 && budget > 0) begin step(); budget--; end
    step(); step();
    do_read(32'd3, 3'd2);
    total++; if (rsp_q.size() !== 1 || rsp_q[0] !== {1'b1, v}) begin
      bad++; $display("FAIL alias_read got=%h n=%0d exp=%h", (rsp_q.size() > 0) ? rsp_q[0] : 33'h0, rsp_q.size(), {1'b1, v});
    end
    do_read(32'd5 * DEPTH + 3, 3'd0);
    total++; if (rsp_q.size() !== 1 || rsp_q[0] !== {1'b1, v}) begin
      bad++; $display("FAIL alias_read_hi got=%h exp=%h", (rsp_q.size() > 0) ? rsp_q[0] : 33'h0, {1'b1, v});
    end
  endtask

  task automatic test_reset_mid_burst();
    int k, budget, n_before;
    k = BURST ? 3 : 1;
    rsp_q.delete(); rsp_cyc.delete();
    push_cmd(32'd8, 32'h0, 4'h0, 1'b0, 3'd5);
    budget = 80;
    while (rsp_q.size() < k && budget > 0) begin step(); budget--; end
    rst_n = 1'b0;
    #1;
    total++; if ({rd_addr, rd_size, wr_data, wr_last} !== 4'b0) begin
      bad++; $display("FAIL rstmid_strobes got=%b exp=0000", {rd_addr, rd_size, wr_data, wr_last});
    end
    total++; if (din_data !== 32'h0 || din_last !== 1'b1) begin
      bad++; $display("FAIL rstmid_din got=%h/%b exp=0/1", din_data, din_last);
    end
    n_before = rsp_q.size();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    total++; if (rsp_q.size() !== n_before) begin bad++; $display("FAIL rstmid_resumed got=%0d exp=%0d", rsp_q.size(), n_before); end
    do_read(32'd200, 3'd0);
    total++; if (rsp_q.size() !== 1 || rsp_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL rstmid_after got=%h exp=%h", (rsp_q.size() > 0) ? rsp_q[0] : 33'h0, exp_q[0]);
    end
    do_read(32'd9, 3'd0);
    total++; if (rsp_q.size() !== 1 || rsp_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL rstmid_ram got=%h exp=%h", (rsp_q.size() > 0) ? rsp_q[0] : 33'h0, exp_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_byte_mask();
    test_burst();
    test_random();
    test_backpressure();
    test_lockstep_alias();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
